// File: rtl/lu_solve_ctrl_if.sv
// Solver-side bundle of lu_solve_ctrl: reset/start/operands out to the forward
// and backward substitution engines, done/result back from them.
interface lu_solve_ctrl_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic             fwd_rst;
    logic             fwd_start;
    logic [N*N*W-1:0] fwd_L;
    logic [N*W-1:0]   fwd_b;
    logic             fwd_done;
    logic [N*W-1:0]   fwd_y;

    logic             bwd_rst;
    logic             bwd_start;
    logic [N*N*W-1:0] bwd_U;
    logic [N*W-1:0]   bwd_y;
    logic             bwd_done;
    logic [N*W-1:0]   bwd_x;

    modport master (
        output fwd_rst, fwd_start, fwd_L, fwd_b,
        input  fwd_done, fwd_y,
        output bwd_rst, bwd_start, bwd_U, bwd_y,
        input  bwd_done, bwd_x
    );

    modport slave (
        input  fwd_rst, fwd_start, fwd_L, fwd_b,
        output fwd_done, fwd_y,
        input  bwd_rst, bwd_start, bwd_U, bwd_y,
        output bwd_done, bwd_x
    );
endinterface

// File: rtl/lu_solve_ctrl.sv
// Column-by-column scheduler building inv(LU) from forward/backward solver runs.
// Optional macro WATCHDOG_EN bounds every solver wait to TIMEOUT cycles.
module lu_solve_ctrl #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int ONE_VAL = 1,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*N*W-1:0]   L_in,
    input  logic [N*N*W-1:0]   U_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [N*N*W-1:0]   inv_out,
    lu_solve_ctrl_if.master    sif
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (N < 2)       begin : g_bad_n   $error("lu_solve_ctrl: N must be at least 2");       end
    if (TIMEOUT < 2) begin : g_bad_to  $error("lu_solve_ctrl: TIMEOUT must be at least 2"); end

    typedef enum logic [2:0] {
        IDLE, F_RST, F_GO, F_WAIT, B_RST, B_GO, B_WAIT, NEXT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N*N*W-1:0] inv_q, inv_d;
    logic [N*N*W-1:0] l_q, l_d;
    logic [N*N*W-1:0] u_q, u_d;
    logic             fwd_rst_q, fwd_rst_d;
    logic             fwd_start_q, fwd_start_d;
    logic             bwd_rst_q, bwd_rst_d;
    logic             bwd_start_q, bwd_start_d;
    logic [N*W-1:0]   fwd_b_q, fwd_b_d;
    logic [N*W-1:0]   bwd_y_q, bwd_y_d;

`ifdef WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic             err_q, err_d;
    logic [TW-1:0]    wd_q, wd_d;
`endif

    // Right-hand side for column c: ONE_VAL at element c, zero elsewhere.
    function automatic logic [N*W-1:0] unit_vec(input logic [CW-1:0] c);
        logic [N*W-1:0] v;
        v = '0;
        v[int'(c)*W +: W] = W'(ONE_VAL);
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        busy_d      = busy_q;
        done_d      = done_q;
        inv_d       = inv_q;
        l_d         = l_q;
        u_d         = u_q;
        fwd_b_d     = fwd_b_q;
        bwd_y_d     = bwd_y_q;
        fwd_rst_d   = 1'b0;
        fwd_start_d = 1'b0;
        bwd_rst_d   = 1'b0;
        bwd_start_d = 1'b0;
`ifdef WATCHDOG_EN
        err_d       = err_q;
        wd_d        = wd_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    l_d       = L_in;
                    u_d       = U_in;
                    col_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
`ifdef WATCHDOG_EN
                    err_d     = 1'b0;
`endif
                    fwd_rst_d = 1'b1;
                    fwd_b_d   = unit_vec('0);
                    state_d   = F_RST;
                end
            end
            F_RST: begin
                fwd_start_d = 1'b1;
                state_d     = F_GO;
            end
            F_GO: begin
`ifdef WATCHDOG_EN
                wd_d    = '0;
`endif
                state_d = F_WAIT;
            end
            F_WAIT: begin
                if (sif.fwd_done) begin
                    bwd_y_d   = sif.fwd_y;
                    bwd_rst_d = 1'b1;
                    state_d   = B_RST;
                end
            end
            B_RST: begin
                bwd_start_d = 1'b1;
                state_d     = B_GO;
            end
            B_GO: begin
`ifdef WATCHDOG_EN
                wd_d    = '0;
`endif
                state_d = B_WAIT;
            end
            B_WAIT: begin
                if (sif.bwd_done) begin
                    for (int r = 0; r < N; r++) begin
                        inv_d[(r*N + int'(col_q))*W +: W] = sif.bwd_x[r*W +: W];
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (col_q == CW'(N-1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    col_d     = col_q + 1'b1;
                    fwd_rst_d = 1'b1;
                    fwd_b_d   = unit_vec(col_q + 1'b1);
                    state_d   = F_RST;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef WATCHDOG_EN
        // A hung solver aborts the whole inversion; both engines get reset on the way out.
        if ((state_q == F_WAIT && !sif.fwd_done) || (state_q == B_WAIT && !sif.bwd_done)) begin
            if (wd_q == TW'(TIMEOUT-1)) begin
                err_d     = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                fwd_rst_d = 1'b1;
                bwd_rst_d = 1'b1;
                state_d   = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inv_q       <= '0;
            l_q         <= '0;
            u_q         <= '0;
            fwd_rst_q   <= 1'b1;
            fwd_start_q <= 1'b0;
            bwd_rst_q   <= 1'b1;
            bwd_start_q <= 1'b0;
            fwd_b_q     <= '0;
            bwd_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inv_q       <= inv_d;
            l_q         <= l_d;
            u_q         <= u_d;
            fwd_rst_q   <= fwd_rst_d;
            fwd_start_q <= fwd_start_d;
            bwd_rst_q   <= bwd_rst_d;
            bwd_start_q <= bwd_start_d;
            fwd_b_q     <= fwd_b_d;
            bwd_y_q     <= bwd_y_d;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign inv_out       = inv_q;
    assign sif.fwd_rst   = fwd_rst_q;
    assign sif.fwd_start = fwd_start_q;
    assign sif.fwd_L     = l_q;
    assign sif.fwd_b     = fwd_b_q;
    assign sif.bwd_rst   = bwd_rst_q;
    assign sif.bwd_start = bwd_start_q;
    assign sif.bwd_U     = u_q;
    assign sif.bwd_y     = bwd_y_q;
endmodule

// File: tb/tb_lu_solve_ctrl.sv
// Directed bench: two controllers (ONE_VAL=1 and ONE_VAL=4) driven by the same
// host stimulus, each paired with behavioural substitution solvers of latency 3.
module tb_lu_solve_ctrl;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MW = N*N*W;
    localparam int VW = N*W;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [MW-1:0] l_in = '0;
    logic [MW-1:0] u_in = '0;
    logic          hold_bwd = 1'b0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    // Matrix with d on the diagonal, e10 at (1,0), zero elsewhere.
    function automatic logic [MW-1:0] mk(input int d, input int e10);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = d;
        m[(1*N+0)*W +: W] = e10;
        return m;
    endfunction

    function automatic logic [VW-1:0] fwd_solve(input logic [MW-1:0] m, input logic [VW-1:0] b);
        int y[N];
        int s, d;
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = $signed(b[i*W +: W]);
            for (int j = 0; j < i; j++) s = s - $signed(m[(i*N+j)*W +: W]) * y[j];
            d = $signed(m[(i*N+i)*W +: W]);
            if (d == 0) d = 1;
            y[i] = s / d;
            r[i*W +: W] = y[i];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] bwd_solve(input logic [MW-1:0] m, input logic [VW-1:0] yv);
        int x[N];
        int s, d;
        logic [VW-1:0] r;
        r = '0;
        for (int i = N-1; i >= 0; i--) begin
            s = $signed(yv[i*W +: W]);
            for (int j = i+1; j < N; j++) s = s - $signed(m[(i*N+j)*W +: W]) * x[j];
            d = $signed(m[(i*N+i)*W +: W]);
            if (d == 0) d = 1;
            x[i] = s / d;
            r[i*W +: W] = x[i];
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int OV = (gi == 0) ? 1 : 4;
        lu_solve_ctrl_if #(.N(N), .W(W)) sif ();
        logic          busy, done, err;
        logic [MW-1:0] inv_out;
        logic [1:0]    fpipe, bpipe;
        logic          fdone, bdone;
        logic [VW-1:0] fy, bx;
        int            fwd_cnt = 0;
        int            bwd_cnt = 0;
        int            viol = 0;
        logic          prev_frst = 1'b0, prev_fstart = 1'b0;
        logic          prev_brst = 1'b0, prev_bstart = 1'b0;
        logic          fbad, bbad;

        lu_solve_ctrl #(.N(N), .W(W), .ONE_VAL(OV), .TIMEOUT(TIMEOUT)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .L_in(l_in), .U_in(u_in),
            .busy(busy), .done(done), .err(err), .inv_out(inv_out), .sif(sif)
        );

        always @(posedge clk) begin
            if (sif.fwd_rst) begin
                fpipe <= '0; fdone <= 1'b0; fy <= '0;
            end else begin
                fpipe <= {fpipe[0], sif.fwd_start};
                if (fpipe[1]) fdone <= 1'b1;
                if (sif.fwd_start) fy <= fwd_solve(sif.fwd_L, sif.fwd_b);
            end
        end

        always @(posedge clk) begin
            if (sif.bwd_rst) begin
                bpipe <= '0; bdone <= 1'b0; bx <= '0;
            end else begin
                bpipe <= {bpipe[0], sif.bwd_start};
                if (bpipe[1] && !hold_bwd) bdone <= 1'b1;
                if (sif.bwd_start) bx <= bwd_solve(sif.bwd_U, sif.bwd_y);
            end
        end

        assign sif.fwd_done = fdone;
        assign sif.fwd_y    = fy;
        assign sif.bwd_done = bdone;
        assign sif.bwd_x    = bx;

        // Each start must follow a one-cycle reset of its solver, be one cycle wide, and not overlap.
        assign fbad = sif.fwd_start && (!prev_frst || prev_fstart || sif.fwd_rst || sif.bwd_start);
        assign bbad = sif.bwd_start && (!prev_brst || prev_bstart || sif.bwd_rst || sif.fwd_rst);

        always @(negedge clk) begin
            fwd_cnt     <= fwd_cnt + int'(sif.fwd_start);
            bwd_cnt     <= bwd_cnt + int'(sif.bwd_start);
            viol        <= viol + int'(fbad) + int'(bbad);
            prev_frst   <= sif.fwd_rst;
            prev_fstart <= sif.fwd_start;
            prev_brst   <= sif.bwd_rst;
            prev_bstart <= sif.bwd_start;
        end
    end

    task automatic check_eq(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full inversion; optionally re-pulses start and changes L_in/U_in during column 1.
    task automatic run(input string tag, input bit inject);
        int cyc, f0, b0, v0;
        bit injd;
        f0 = g_inst[0].fwd_cnt;
        b0 = g_inst[0].bwd_cnt;
        v0 = g_inst[0].viol + g_inst[1].viol;
        injd = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (inject && !injd && g_inst[0].fwd_cnt == f0 + 2) begin
                start = 1'b1;
                injd  = 1'b1;
                l_in  = mk(1, 0);
                u_in  = mk(3, 0);
            end
        end while (!(g_inst[0].done && g_inst[1].done) && cyc < 500);
        start = 1'b0;
        check_eq({tag, "_cycles"}, cyc, 45);
        check_eq({tag, "_fwd_starts"}, g_inst[0].fwd_cnt - f0, 4);
        check_eq({tag, "_bwd_starts"}, g_inst[0].bwd_cnt - b0, 4);
        check_eq({tag, "_pulse_viol"}, g_inst[0].viol + g_inst[1].viol - v0, 0);
        check_eq({tag, "_busy_done_err"}, {g_inst[0].busy, g_inst[0].done, g_inst[0].err,
                                          g_inst[1].busy, g_inst[1].done, g_inst[1].err}, 6'b010010);
        $display("run %s: cycles=%0d inject=%0d", tag, cyc, inject);
    endtask

    initial begin
        int n, b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {g_inst[0].busy, g_inst[0].done, g_inst[0].err, g_inst[0].sif.fwd_rst,
                             g_inst[0].sif.fwd_start, g_inst[0].sif.bwd_rst, g_inst[0].sif.bwd_start}, 7'b0001010);
        check_eq("rst_inv", g_inst[0].inv_out, '0);
        check_eq("rst_vec", {g_inst[0].sif.fwd_b, g_inst[0].sif.bwd_y}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_rst_low", {g_inst[0].sif.fwd_rst, g_inst[0].sif.bwd_rst}, 2'b00);

        l_in = mk(1, 0); u_in = mk(1, 0);
        run("ident", 1'b0);
        check_eq("ident_inv1", g_inst[0].inv_out, mk(1, 0));
        check_eq("ident_inv4", g_inst[1].inv_out, mk(4, 0));

        u_in = mk(2, 0);
        run("udiag2", 1'b0);
        check_eq("udiag2_inv4", g_inst[1].inv_out, mk(2, 0));

        l_in = mk(1, 2); u_in = mk(1, 0);
        run("lchg", 1'b1);
        check_eq("lchg_inv1", g_inst[0].inv_out, mk(1, -2));
        check_eq("lchg_inv4", g_inst[1].inv_out, mk(4, -8));

        l_in = mk(1, 0); u_in = mk(2, 0);
        b0 = g_inst[0].bwd_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (g_inst[0].bwd_cnt < b0 + 3 && n < 200) begin @(negedge clk); n++; end
        check_eq("midrst_reach", n < 200, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_ctl", {g_inst[0].busy, g_inst[0].done, g_inst[0].err, g_inst[0].sif.fwd_rst,
                                g_inst[0].sif.fwd_start, g_inst[0].sif.bwd_rst, g_inst[0].sif.bwd_start}, 7'b0001010);
        check_eq("midrst_inv", g_inst[1].inv_out, '0);
        check_eq("midrst_vec", {g_inst[1].sif.fwd_b, g_inst[1].sif.bwd_y}, '0);
        $display("run midrst: reset asserted in B_WAIT column 2");
        rst_n = 1'b1;
        @(negedge clk);
        run("after_rst", 1'b0);
        check_eq("after_rst_inv4", g_inst[1].inv_out, mk(2, 0));

`ifdef WATCHDOG_EN
        hold_bwd = 1'b1;
        l_in = mk(1, 0); u_in = mk(1, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!g_inst[0].sif.bwd_start && n < 100) begin @(negedge clk); n++; end
        check_eq("wd_reach_bgo", n < 100, 1'b1);
        @(negedge clk);
        n = 0;
        while (!g_inst[0].err && n < 200) begin @(negedge clk); n++; end
        check_eq("wd_latency", n, TIMEOUT);
        check_eq("wd_flags", {g_inst[0].busy, g_inst[0].done, g_inst[0].err}, 3'b001);
        $display("run watchdog: err after %0d cycles", n);
        hold_bwd = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lu_solve_ctrl.md
Name: lu_solve_ctrl

Overview:
- Scheduler that produces a 4x4 inverse from precomputed L and U factors.
- For each column k of the scaled identity it runs the forward solver (L·y = e_k), then the backward solver (U·x = y), and stores x as column k of the result.
- Sits between the matrix-inversion top and the forward/backward solver instances; owns their start and reset sequencing and all data routing.

Parameters:
- N, 4, matrix order (design verified at 4 only).
- W, 32, element width, signed integer.
- ONE_VAL, 1, value placed on the identity diagonal (fixed-point scale).
- TIMEOUT, 64, watchdog cycle limit per solver run (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled in IDLE only.
- L_in  in  N*N*W  flattened L, element (r,c) at index r*N+c.
- U_in  in  N*N*W  flattened U, same layout.
- busy  out  1  high from start acceptance until done.
- done  out  1  level; high after all N columns complete, cleared on next accepted start.
- err  out  1  watchdog error flag (always 0 without WATCHDOG_EN).
- inv_out  out  N*N*W  flattened inverse, element (r,k) at index r*N+k.
- fwd_rst  out  1  active-high synchronous reset to forward solver.
- fwd_start  out  1  forward solver start.
- fwd_L  out  N*N*W  latched L.
- fwd_b  out  N*W  e_k scaled by ONE_VAL.
- fwd_done  in  1  forward solver done (level).
- fwd_y  in  N*W  forward result.
- bwd_rst  out  1  backward solver reset.
- bwd_start  out  1  backward solver start.
- bwd_U  out  N*N*W  latched U.
- bwd_y  out  N*W  registered copy of fwd_y.
- bwd_done  in  1  backward solver done (level).
- bwd_x  in  N*W  backward result.

Behaviour:
- Reset (async, rst_n=0): state IDLE, col=0, busy=0, done=0, err=0, inv_out=0, fwd_rst=bwd_rst=1, both starts 0, fwd_b=0, bwd_y=0.
- Solvers hold done high until they are reset. Every run is therefore preceded by a one-cycle reset pulse to that solver.
- IDLE: fwd_rst=bwd_rst=0.
  - On start: latch L_in/U_in into fwd_L/bwd_U, col=0, busy=1, done=0, err=0, go to F_RST.
  - A start seen outside IDLE is ignored.
- F_RST: fwd_rst=1 for one cycle; fwd_b = ONE_VAL at element col, 0 elsewhere; go to F_GO.
- F_GO: fwd_start=1 for one cycle; go to F_WAIT.
- F_WAIT: wait for fwd_done=1, then capture bwd_y<=fwd_y and go to B_RST.
- B_RST: bwd_rst=1 for one cycle; go to B_GO.
- B_GO: bwd_start=1 for one cycle; go to B_WAIT.
- B_WAIT: wait for bwd_done=1, then write bwd_x element r into inv_out(r,col) for r=0..N-1; go to NEXT.
- NEXT:
  - If col==N-1: busy=0, done=1, go to IDLE.
  - Else col=col+1, go to F_RST.
- start/rst pulses are exactly one cycle and never overlap.
- fwd_L/bwd_U stay constant for the whole operation, even if L_in/U_in change.
- inv_out columns not yet written keep their previous values (0 after reset). Other columns are untouched during a write.
- No arithmetic in this block; data is routed unchanged, with no width change.
- Reset mid-operation: immediate return to reset values. No partial done is produced.
- done and start in the same cycle (IDLE): start is accepted and done clears next cycle.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined:
  - Per-run cycle counter, cleared on entering F_WAIT/B_WAIT, incremented each wait cycle.
  - When it reaches TIMEOUT: err=1, busy=0, done=0, both solver resets asserted for one cycle, return to IDLE.
  - err clears on next accepted start.
- Not defined: the wait states are unbounded; err is tied to 0 and no counter logic exists.

Test Plan:
- L=I, U=I, ONE_VAL=1, start -> done=1, inv_out = identity. Exactly 4 fwd_start and 4 bwd_start pulses, each preceded by a one-cycle rst pulse.
- L=I, U=diag(2,2,2,2), ONE_VAL=4 -> inv_out diagonal = 2, off-diagonal = 0.
- Solver models with done latency 3 cycles -> total start-to-done = 4·(1+1+3+1+1+3+1)+1 cycles.
- Both of the following are ignored (no extra pulses, result unchanged):
  - start reasserted during col 1.
  - L_in changed mid-operation.
- rst_n low while in B_WAIT col 2 -> all outputs at reset values next cycle. A new start then produces the correct full inverse.
- WATCHDOG_EN, TIMEOUT=64, bwd_done held 0 -> err=1 exactly 64 cycles after entering B_WAIT, busy=0, done=0.
